// File: rtl/program_memory_boot_if.sv
// program_memory_boot_if: bus between the host/fetch side and the boot-loading instruction store.
// Signals:
//   fetch_en, fetch_addr      fetch request and address (master -> slave)
//   instruction, instr_valid  registered fetch data and its valid flag (slave -> master)
//   boot_start, boot_base,
//   boot_len                  boot start pulse, first load address, word count (master -> slave)
//   byte_data, byte_valid     load byte stream (master -> slave)
//   byte_ready                loader accepts a byte (slave -> master)
//   boot_busy, boot_done      loader busy level and one-cycle completion pulse (slave -> master)
//   checksum                  sum mod 256 of bytes accepted in the current boot (slave -> master)
interface program_memory_boot_if #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
);
   logic             fetch_en;
   logic [AW-1:0]    fetch_addr;
   logic [WIDTH-1:0] instruction;
   logic             instr_valid;
   logic             boot_start;
   logic [AW-1:0]    boot_base;
   logic [AW:0]      boot_len;
   logic [7:0]       byte_data;
   logic             byte_valid;
   logic             byte_ready;
   logic             boot_busy;
   logic             boot_done;
   logic [7:0]       checksum;
   modport slave (
      input  fetch_en, fetch_addr, boot_start, boot_base, boot_len, byte_data, byte_valid,
      output instruction, instr_valid, byte_ready, boot_busy, boot_done, checksum
   );
   modport master (
      output fetch_en, fetch_addr, boot_start, boot_base, boot_len, byte_data, byte_valid,
      input  instruction, instr_valid, byte_ready, boot_busy, boot_done, checksum
   );
endinterface

// File: rtl/program_memory_boot.sv
// program_memory_boot: instruction store with a byte-stream boot loader and registered fetch port.
// Ports:
//   clk  clock, all logic on the rising edge
//   rst  asynchronous active-high reset (memory contents are kept)
//   bus  program_memory_boot_if.slave: fetch request/data, boot control, byte stream, status
module program_memory_boot #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 256
) (
   input logic                  clk,
   input logic                  rst,
   program_memory_boot_if.slave bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int BPW = (WIDTH + 7) / 8;
   localparam int BIW = BPW > 1 ? $clog2(BPW) : 1;
   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
   state_t           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [AW:0]      remain_q, remain_d;
   logic [BIW-1:0]   byte_idx_q, byte_idx_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [7:0]       checksum_q, checksum_d;
   logic [WIDTH-1:0] instruction_q, instruction_d;
   logic             instr_valid_q, instr_valid_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             busy, xfer, last, rd_ok, in_range;
   always_comb begin
      busy          = state_q == RECV || state_q == WRITE;
      xfer          = state_q == RECV && bus.byte_valid;
      last          = byte_idx_q == BIW'(BPW - 1);
      rd_ok         = bus.fetch_en && !busy;
      in_range      = {1'b0, bus.fetch_addr} < (AW + 1)'(DEPTH);
      instr_valid_d = rd_ok;
      instruction_d = rd_ok && in_range ? mem[bus.fetch_addr] : '0;
      state_d       = state_q;
      addr_d        = addr_q;
      remain_d      = remain_q;
      byte_idx_d    = byte_idx_q;
      word_d        = word_q;
      checksum_d    = checksum_q;
      case (state_q)
         IDLE: if (bus.boot_start) begin
            state_d    = bus.boot_len != '0 ? RECV : DONE;
            addr_d     = bus.boot_base;
            remain_d   = bus.boot_len;
            byte_idx_d = '0;
            checksum_d = '0;
         end
         RECV: if (xfer) begin
            // Little-endian lane insert; bits of the last byte above WIDTH-1 fall away.
            for (int b = 0; b < WIDTH; b++)
               if (b / 8 == int'(byte_idx_q)) word_d[b] = bus.byte_data[b % 8];
            checksum_d = checksum_q + bus.byte_data;
            byte_idx_d = last ? '0 : byte_idx_q + BIW'(1);
            state_d    = last ? WRITE : RECV;
         end
         WRITE: begin
            addr_d   = addr_q == AW'(DEPTH - 1) ? '0 : addr_q + AW'(1);
            remain_d = remain_q - (AW + 1)'(1);
            state_d  = remain_q == (AW + 1)'(1) ? DONE : RECV;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         remain_q      <= '0;
         byte_idx_q    <= '0;
         word_q        <= '0;
         checksum_q    <= '0;
         instruction_q <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remain_q      <= remain_d;
         byte_idx_q    <= byte_idx_d;
         word_q        <= word_d;
         checksum_q    <= checksum_d;
         instruction_q <= instruction_d;
         instr_valid_q <= instr_valid_d;
      end
   // Storage has no reset; an async reset forces IDLE, so no write follows it.
   always_ff @(posedge clk)
      if (state_q == WRITE) mem[addr_q] <= word_q;
   assign bus.instruction = instruction_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.byte_ready  = state_q == RECV;
   assign bus.boot_busy   = busy;
   assign bus.boot_done   = state_q == DONE;
   assign bus.checksum    = checksum_q;
endmodule

// File: tb/tb_program_memory_boot.sv
// tb_program_memory_boot: directed self-checking bench for program_memory_boot (WIDTH=12, DEPTH=256).
module tb_program_memory_boot;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] bv [8];
   logic [11:0] f_data;
   logic        f_valid;
   int          stalls;
   program_memory_boot_if #(.WIDTH(12), .DEPTH(256)) bus();
   program_memory_boot #(.WIDTH(12), .DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic fetch(input logic [7:0] a, output logic [11:0] d, output logic v);
      bus.fetch_en   = 1'b1;
      bus.fetch_addr = a;
      tick();
      d = bus.instruction;
      v = bus.instr_valid;
      bus.fetch_en = 1'b0;
   endtask
   task automatic expect_mem(input string tag, input logic [7:0] a, input logic [11:0] exp);
      fetch(a, f_data, f_valid);
      check({tag, "_valid"}, 32'(f_valid), 32'd1);
      check(tag, 32'(f_data), 32'(exp));
   endtask
   task automatic boot(input logic [7:0] base, input logic [8:0] len, input int n,
                       input bit gaps, input bit wait_done, output int st);
      int idx = 0;
      int cyc = 0;
      bit acc;
      bus.boot_base  = base;
      bus.boot_len   = len;
      bus.boot_start = 1'b1;
      tick();
      bus.boot_start = 1'b0;
      st = 0;
      while (idx < n && cyc < 200) begin
         bus.byte_valid = !(gaps && $urandom_range(0, 2) == 0);
         bus.byte_data  = bv[idx];
         if (bus.byte_valid && !bus.byte_ready) st++;
         acc = bus.byte_valid && bus.byte_ready;
         tick();
         if (acc) idx++;
         cyc++;
      end
      bus.byte_valid = 1'b0;
      if (idx < n) check("feed_timeout", 32'(idx), 32'(n));
      if (wait_done) begin
         check("done_in_write", 32'(bus.boot_done), 32'd0);
         tick();
         check("done_pulse", 32'(bus.boot_done), 32'd1);
         tick();
         check("done_clear", 32'(bus.boot_done), 32'd0);
         check("idle_busy", 32'(bus.boot_busy), 32'd0);
      end
   endtask
   initial begin
      // 1: reset with busy-looking inputs
      bus.fetch_en = 1'b1; bus.fetch_addr = 8'h05; bus.boot_start = 1'b1; bus.boot_base = 8'h33;
      bus.boot_len = 9'd4; bus.byte_data = 8'hA5; bus.byte_valid = 1'b1;
      repeat (3) tick();
      check("rst_instruction", 32'(bus.instruction), 32'd0);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      check("rst_boot_busy", 32'(bus.boot_busy), 32'd0);
      check("rst_boot_done", 32'(bus.boot_done), 32'd0);
      check("rst_checksum", 32'(bus.checksum), 32'd0);
      bus.fetch_en = 1'b0; bus.boot_start = 1'b0; bus.byte_valid = 1'b0;
      rst = 1'b0;
      tick();
      // 2: basic two-word boot
      bv[0] = 8'h34; bv[1] = 8'h12; bv[2] = 8'hCD; bv[3] = 8'hAB;
      boot(8'h00, 9'd2, 4, 1'b0, 1'b1, stalls);
      check("basic_checksum", 32'(bus.checksum), 32'hBE);
      check("fetch_idle_valid", 32'(bus.instr_valid), 32'd0);
      expect_mem("basic_mem0", 8'h00, 12'h234);
      expect_mem("basic_mem1", 8'h01, 12'hBCD);
      tick();
      check("fetch_drop_valid", 32'(bus.instr_valid), 32'd0);
      check("fetch_drop_data", 32'(bus.instruction), 32'd0);
      // 3: wrap from the top address
      bv[0] = 8'h11; bv[1] = 8'h0A; bv[2] = 8'h22; bv[3] = 8'h0B;
      boot(8'hFF, 9'd2, 4, 1'b0, 1'b1, stalls);
      check("wrap_checksum", 32'(bus.checksum), 32'h48);
      expect_mem("wrap_memFF", 8'hFF, 12'hA11);
      expect_mem("wrap_mem00", 8'h00, 12'hB22);
      expect_mem("wrap_mem01", 8'h01, 12'hBCD);
      // 4: continuous valid, then random gaps
      bv[0] = 8'h01; bv[1] = 8'hF1; bv[2] = 8'h02; bv[3] = 8'hF2; bv[4] = 8'h03; bv[5] = 8'hF3;
      boot(8'h20, 9'd3, 6, 1'b0, 1'b1, stalls);
      check("bp_stalls", 32'(stalls), 32'd2);
      check("bp_checksum", 32'(bus.checksum), 32'hDC);
      expect_mem("bp_mem20", 8'h20, 12'h101);
      expect_mem("bp_mem21", 8'h21, 12'h202);
      expect_mem("bp_mem22", 8'h22, 12'h303);
      boot(8'h20, 9'd3, 6, 1'b1, 1'b1, stalls);
      check("gap_checksum", 32'(bus.checksum), 32'hDC);
      expect_mem("gap_mem20", 8'h20, 12'h101);
      expect_mem("gap_mem21", 8'h21, 12'h202);
      expect_mem("gap_mem22", 8'h22, 12'h303);
      // 5: reset after three of four bytes
      bv[0] = 8'h55; bv[1] = 8'h05; bv[2] = 8'h66; bv[3] = 8'h06;
      boot(8'h10, 9'd2, 4, 1'b0, 1'b1, stalls);
      bv[0] = 8'h77; bv[1] = 8'h07; bv[2] = 8'h88;
      boot(8'h10, 9'd2, 3, 1'b0, 1'b0, stalls);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(bus.boot_busy), 32'd0);
      tick();
      rst = 1'b0;
      repeat (2) tick();
      check("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
      check("mid_rst_done", 32'(bus.boot_done), 32'd0);
      check("mid_rst_checksum", 32'(bus.checksum), 32'd0);
      expect_mem("mid_rst_mem10", 8'h10, 12'h777);
      expect_mem("mid_rst_mem11", 8'h11, 12'h666);
      bv[0] = 8'h9A; bv[1] = 8'h09;
      boot(8'h30, 9'd1, 2, 1'b0, 1'b1, stalls);
      check("after_rst_checksum", 32'(bus.checksum), 32'hA3);
      expect_mem("after_rst_mem30", 8'h30, 12'h99A);
      // 6a: zero-length boot
      bus.boot_base = 8'h00; bus.boot_len = 9'd0; bus.boot_start = 1'b1;
      tick();
      bus.boot_start = 1'b0;
      check("len0_done", 32'(bus.boot_done), 32'd1);
      check("len0_busy", 32'(bus.boot_busy), 32'd0);
      check("len0_checksum", 32'(bus.checksum), 32'd0);
      tick();
      check("len0_done_clear", 32'(bus.boot_done), 32'd0);
      expect_mem("len0_mem00", 8'h00, 12'hB22);
      // 6b: fetch and restart attempts during a boot
      bus.boot_base = 8'h40; bus.boot_len = 9'd1; bus.boot_start = 1'b1;
      tick();
      bus.boot_start = 1'b0;
      check("busy_in_recv", 32'(bus.boot_busy), 32'd1);
      fetch(8'h00, f_data, f_valid);
      check("busy_fetch_valid", 32'(f_valid), 32'd0);
      check("busy_fetch_data", 32'(f_data), 32'd0);
      bus.boot_base = 8'h50; bus.boot_len = 9'd2; bus.boot_start = 1'b1;
      bus.byte_data = 8'h21; bus.byte_valid = 1'b1;
      tick();
      bus.boot_start = 1'b0;
      bus.byte_data = 8'h04;
      tick();
      bus.byte_valid = 1'b0;
      check("restart_write", 32'(bus.byte_ready), 32'd0);
      tick();
      check("restart_done", 32'(bus.boot_done), 32'd1);
      check("restart_checksum", 32'(bus.checksum), 32'h25);
      tick();
      expect_mem("restart_mem40", 8'h40, 12'h421);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
